// File: rtl/sram_arb_pkg.sv
// Shared definitions for the two-master SRAM port arbiter.
// Contents:
//   arb_state_t   - arbiter state encoding (ARB / OWN0 / OWN1)
//   ID_M0, ID_M1  - master identifiers carried through the read tracker
//   DEF_AW/DEF_DW - default SRAM address / data widths (1K x 32)
//   other_id()    - the opposite master of a given id
package sram_arb_pkg;

    typedef enum logic [1:0] {
        ST_ARB  = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

    localparam logic ID_M0 = 1'b0;
    localparam logic ID_M1 = 1'b1;

    localparam int DEF_AW = 10;
    localparam int DEF_DW = 32;

    function automatic logic other_id(input logic id);
        return ~id;
    endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Request/response bundle between one master and the SRAM port arbiter.
// Signals:
//   req    - access request, held until gnt
//   wen    - 1 = write, 0 = read
//   lock   - keep ownership after this access
//   addr   - word address
//   wdata  - write data
//   gnt    - accept, combinational from the arbiter
//   rvalid - one-cycle read-data-valid pulse
//   rdata  - read data, qualified by rvalid
// Modports: master (requester side), slave (arbiter side).
interface sram_port_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic          req;
    logic          wen;
    logic          lock;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (
        output req, wen, lock, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, wen, lock, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/sram_rd_tracker.sv
// Read-return tracker: a {valid, id} shift pipeline of depth 1+RD_LAT.
// A read accepted in cycle n enters the pipe at the end of cycle n and
// reaches the last stage in cycle n+1+RD_LAT, the cycle in which the SRAM
// presents the data.
// Ports:
//   i_clk      - clock
//   i_rst      - synchronous active-high reset; drops all reads in flight
//   i_push     - a read is accepted this cycle
//   i_id       - id of the master that issued it
//   o_rvalid0  - read data valid for master 0
//   o_rvalid1  - read data valid for master 1
module sram_rd_tracker
    import sram_arb_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_push,
    input  logic i_id,
    output logic o_rvalid0,
    output logic o_rvalid1
);
    localparam int DEPTH = 1 + RD_LAT;

    logic [DEPTH-1:0] r_vld;
    logic [DEPTH-1:0] r_id;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld <= '0;
            r_id  <= '0;
        end else begin
            r_vld <= {r_vld[DEPTH-2:0], i_push};
            r_id  <= {r_id[DEPTH-2:0], i_id};
        end
    end

    assign o_rvalid0 = r_vld[DEPTH-1] & (r_id[DEPTH-1] == ID_M0);
    assign o_rvalid1 = r_vld[DEPTH-1] & (r_id[DEPTH-1] == ID_M1);
endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between two masters,
// with per-master lock for exclusive bursts.
// Ports:
//   HCLK, RST  - clock, synchronous active-high reset
//   m0, m1     - master request/response bundles (slave modport)
//   mem_en     - SRAM enable, one cycle per accepted access (registered)
//   mem_wen    - SRAM write enable (registered)
//   mem_addr   - SRAM address, holds last value when idle (registered)
//   mem_wdata  - SRAM write data, holds last value when idle (registered)
//   mem_rdata  - SRAM read data, forwarded to both masters
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int AW     = DEF_AW,
    parameter int DW     = DEF_DW,
    parameter int RD_LAT = 1
) (
    input  logic                 HCLK,
    input  logic                 RST,
    sram_port_arbiter_if.slave   m0,
    sram_port_arbiter_if.slave   m1,
    output logic                 mem_en,
    output logic                 mem_wen,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    input  logic [DW-1:0]        mem_rdata
);
    arb_state_t    r_state;
    logic          r_ptr;
    logic          r_mem_en;
    logic          r_mem_wen;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;

    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_acc;
    logic          w_sel_id;
    logic          w_sel_wen;
    logic          w_sel_lock;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;
    logic          w_rvalid0;
    logic          w_rvalid1;

    // Grant decode. The pointer only breaks ties; an uncontested request in
    // ARB is granted regardless of it.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!RST) begin
            case (r_state)
                ST_ARB: begin
                    if (m0.req && m1.req) begin
                        if (r_ptr == ID_M0) w_gnt0 = 1'b1;
                        else                w_gnt1 = 1'b1;
                    end else begin
                        w_gnt0 = m0.req;
                        w_gnt1 = m1.req;
                    end
                end
                ST_OWN0: w_gnt0 = m0.req;
                ST_OWN1: w_gnt1 = m1.req;
                default: ;
            endcase
        end
    end

    assign w_acc       = w_gnt0 | w_gnt1;
    assign w_sel_id    = w_gnt1 ? ID_M1 : ID_M0;
    assign w_sel_wen   = w_gnt1 ? m1.wen   : m0.wen;
    assign w_sel_lock  = w_gnt1 ? m1.lock  : m0.lock;
    assign w_sel_addr  = w_gnt1 ? m1.addr  : m0.addr;
    assign w_sel_wdata = w_gnt1 ? m1.wdata : m0.wdata;

    always_ff @(posedge HCLK) begin
        if (RST) begin
            r_state     <= ST_ARB;
            r_ptr       <= ID_M0;
            r_mem_en    <= 1'b0;
            r_mem_wen   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_en  <= w_acc;
            r_mem_wen <= w_acc & w_sel_wen;
            if (w_acc) begin
                r_mem_addr  <= w_sel_addr;
                r_mem_wdata <= w_sel_wdata;
            end

            case (r_state)
                ST_ARB: begin
                    if (w_acc) begin
                        if (m0.req && m1.req) r_ptr <= other_id(w_sel_id);
                        if (w_sel_lock)
                            r_state <= (w_sel_id == ID_M1) ? ST_OWN1 : ST_OWN0;
                    end
                end
                ST_OWN0: begin
                    if (w_acc && !m0.lock) begin
                        r_state <= ST_ARB;
                        r_ptr   <= ID_M1;
                    end else if (!m0.req && !m0.lock) begin
                        // Owner abandoned the burst without a final access.
                        r_state <= ST_ARB;
                    end
                end
                ST_OWN1: begin
                    if (w_acc && !m1.lock) begin
                        r_state <= ST_ARB;
                        r_ptr   <= ID_M0;
                    end else if (!m1.req && !m1.lock) begin
                        r_state <= ST_ARB;
                    end
                end
                default: r_state <= ST_ARB;
            endcase
        end
    end

    sram_rd_tracker #(.RD_LAT(RD_LAT)) u_rd_tracker (
        .i_clk     (HCLK),
        .i_rst     (RST),
        .i_push    (w_acc & ~w_sel_wen),
        .i_id      (w_sel_id),
        .o_rvalid0 (w_rvalid0),
        .o_rvalid1 (w_rvalid1)
    );

    assign m0.gnt    = w_gnt0;
    assign m1.gnt    = w_gnt1;
    assign m0.rvalid = w_rvalid0;
    assign m1.rvalid = w_rvalid1;
    assign m0.rdata  = mem_rdata;
    assign m1.rdata  = mem_rdata;

    assign mem_en    = r_mem_en;
    assign mem_wen   = r_mem_wen;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural SRAM model and a
// read-return scoreboard checked by a separate monitor process.
module tb_sram_port_arbiter;
    import sram_arb_pkg::*;

    localparam int AW     = 10;
    localparam int DW     = 32;
    localparam int RD_LAT = 1;

    logic HCLK = 1'b0;
    logic RST  = 1'b1;
    always #5 HCLK = ~HCLK;

    sram_port_arbiter_if #(.AW(AW), .DW(DW)) u_m0 ();
    sram_port_arbiter_if #(.AW(AW), .DW(DW)) u_m1 ();

    logic          mem_en;
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    sram_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .HCLK      (HCLK),
        .RST       (RST),
        .m0        (u_m0),
        .m1        (u_m1),
        .mem_en    (mem_en),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Behavioural single-port SRAM; preload contents are (re)written in reset.
    logic [DW-1:0] sram [0:(1<<AW)-1];
    logic [DW-1:0] rd_pipe [RD_LAT];
    always @(posedge HCLK) begin
        if (RST) begin
            sram[1] <= 32'h1111_1111;
            sram[2] <= 32'h2222_2222;
            sram[3] <= 32'h3333_3333;
            sram[4] <= 32'hDEAD_BEEF;
        end else if (mem_en && mem_wen) begin
            sram[mem_addr] <= mem_wdata;
        end
        rd_pipe[0] <= (mem_en && !mem_wen) ? sram[mem_addr] : 32'hBAD0_BAD0;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[RD_LAT-1];

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    typedef struct {
        logic          id;
        logic [DW-1:0] data;
        int            due;
    } exp_t;
    exp_t sb_q[$];

    int checks   = 0;
    int failures = 0;

    task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        chkw(name, 32'(act), 32'(req));
    endtask

    task automatic tick;
        @(posedge HCLK);
        #1;
    endtask

    task automatic drv0(input logic req, input logic wen, input logic lock,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
        u_m0.req = req; u_m0.wen = wen; u_m0.lock = lock; u_m0.addr = a; u_m0.wdata = d;
    endtask

    task automatic drv1(input logic req, input logic wen, input logic lock,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
        u_m1.req = req; u_m1.wen = wen; u_m1.lock = lock; u_m1.addr = a; u_m1.wdata = d;
    endtask

    // Called in the accept cycle: data is due 1+RD_LAT cycles later.
    task automatic exp_read(input logic id, input logic [DW-1:0] d);
        exp_t e;
        e.id   = id;
        e.data = d;
        e.due  = cyc + 1 + RD_LAT;
        sb_q.push_back(e);
    endtask

    task automatic monitor_loop;
        exp_t e;
        forever begin
            @(negedge HCLK);
            if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
                e = sb_q.pop_front();
                chkw("rvalid_missing", 32'(e.due), 32'(cyc));
            end
            if (u_m0.rvalid || u_m1.rvalid) begin
                if (sb_q.size() == 0) begin
                    chkw("rvalid_unexpected", {30'b0, u_m1.rvalid, u_m0.rvalid}, 32'h0);
                end else begin
                    e = sb_q.pop_front();
                    chkw("rvalid_port", {30'b0, u_m1.rvalid, u_m0.rvalid},
                         e.id ? 32'h2 : 32'h1);
                    chkw("rdata", e.id ? u_m1.rdata : u_m0.rdata, e.data);
                    chkw("rvalid_cycle", 32'(cyc), 32'(e.due));
                end
            end
        end
    endtask

    initial begin
        drv0(1'b1, 1'b0, 1'b0, '0, '0);
        drv1(1'b0, 1'b0, 1'b0, '0, '0);
        fork
            monitor_loop();
        join_none

        // Reset: gnt suppressed, memory-side outputs cleared.
        RST = 1'b1;
        tick; tick;
        @(negedge HCLK);
        chk1("gnt0_in_reset", u_m0.gnt, 1'b0);
        chk1("gnt1_in_reset", u_m1.gnt, 1'b0);
        tick;
        RST = 1'b0;
        drv0(1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge HCLK);
        chk1("rst_mem_en", mem_en, 1'b0);
        chk1("rst_mem_wen", mem_wen, 1'b0);
        chkw("rst_mem_addr", 32'(mem_addr), 32'h0);
        chkw("rst_mem_wdata", mem_wdata, 32'h0);
        chkw("rst_rvalid", {30'b0, u_m1.rvalid, u_m0.rvalid}, 32'h0);

        // Single read by m0 from 0x004.
        tick;
        drv0(1'b1, 1'b0, 1'b0, 10'h004, '0);
        @(negedge HCLK);
        chk1("rd_gnt0", u_m0.gnt, 1'b1);
        chk1("rd_gnt1", u_m1.gnt, 1'b0);
        exp_read(ID_M0, 32'hDEAD_BEEF);
        tick;
        drv0(1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge HCLK);
        chk1("rd_mem_en", mem_en, 1'b1);
        chk1("rd_mem_wen", mem_wen, 1'b0);
        chkw("rd_mem_addr", 32'(mem_addr), 32'h004);
        tick;
        @(negedge HCLK);
        chk1("rd_idle_mem_en", mem_en, 1'b0);
        chkw("rd_idle_addr_hold", 32'(mem_addr), 32'h004);
        tick; tick;

        // Contention: alternating grants every cycle.
        drv0(1'b1, 1'b1, 1'b0, 10'h010, 32'hA0A0_A0A0);
        drv1(1'b1, 1'b1, 1'b0, 10'h020, 32'hB1B1_B1B1);
        for (int k = 0; k < 4; k++) begin
            @(negedge HCLK);
            chk1("rr_gnt0", u_m0.gnt, (k % 2) == 0);
            chk1("rr_gnt1", u_m1.gnt, (k % 2) == 1);
            if (k > 0) begin
                chk1("rr_mem_en", mem_en, 1'b1);
                chkw("rr_mem_addr", 32'(mem_addr), (k % 2) == 1 ? 32'h010 : 32'h020);
            end
            tick;
        end
        drv0(1'b0, 1'b0, 1'b0, '0, '0);
        drv1(1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge HCLK);
        chkw("rr_last_addr", 32'(mem_addr), 32'h020);
        chkw("rr_last_wdata", mem_wdata, 32'hB1B1_B1B1);
        chk1("rr_last_wen", mem_wen, 1'b1);
        tick;

        // Lock burst by m1 while m0 waits.
        drv1(1'b1, 1'b1, 1'b1, 10'h100, 32'hC000_0000);
        @(negedge HCLK);
        chk1("lk_first_gnt1", u_m1.gnt, 1'b1);
        tick;
        drv0(1'b1, 1'b1, 1'b0, 10'h030, 32'hD000_0000);
        for (int j = 1; j < 4; j++) begin
            drv1(1'b1, 1'b1, j < 3, 10'(32'h100 + j), 32'hC000_0000 + j);
            @(negedge HCLK);
            chk1("lk_gnt0_held", u_m0.gnt, 1'b0);
            chk1("lk_gnt1", u_m1.gnt, 1'b1);
            chkw("lk_mem_addr", 32'(mem_addr), 32'h100 + j - 1);
            tick;
        end
        drv1(1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge HCLK);
        chk1("lk_release_gnt0", u_m0.gnt, 1'b1);
        chkw("lk_last_addr", 32'(mem_addr), 32'h103);
        tick;
        drv0(1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge HCLK);
        chkw("lk_m0_addr", 32'(mem_addr), 32'h030);
        tick;

        // Locked idle inside an m1 burst.
        drv1(1'b1, 1'b1, 1'b1, 10'h200, 32'hE000_0000);
        @(negedge HCLK);
        chk1("li_gnt1", u_m1.gnt, 1'b1);
        tick;
        drv1(1'b0, 1'b1, 1'b1, 10'h200, 32'hE000_0000);
        drv0(1'b1, 1'b1, 1'b0, 10'h040, 32'hF000_0000);
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            chk1("li_gnt0", u_m0.gnt, 1'b0);
            chk1("li_gnt1", u_m1.gnt, 1'b0);
            chk1("li_mem_en", mem_en, i == 0);
            tick;
        end
        drv1(1'b1, 1'b1, 1'b0, 10'h201, 32'hE000_0001);
        @(negedge HCLK);
        chk1("li_final_gnt1", u_m1.gnt, 1'b1);
        chk1("li_final_gnt0", u_m0.gnt, 1'b0);
        tick;
        drv1(1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge HCLK);
        chk1("li_after_gnt0", u_m0.gnt, 1'b1);
        chkw("li_final_addr", 32'(mem_addr), 32'h201);
        tick;
        drv0(1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge HCLK);
        chkw("li_m0_addr", 32'(mem_addr), 32'h040);
        tick;

        // Interleaved readback.
        drv0(1'b1, 1'b0, 1'b0, 10'h001, '0);
        @(negedge HCLK);
        chk1("il_gnt0", u_m0.gnt, 1'b1);
        exp_read(ID_M0, 32'h1111_1111);
        tick;
        drv0(1'b0, 1'b0, 1'b0, '0, '0);
        drv1(1'b1, 1'b0, 1'b0, 10'h002, '0);
        @(negedge HCLK);
        chk1("il_gnt1", u_m1.gnt, 1'b1);
        exp_read(ID_M1, 32'h2222_2222);
        tick;
        drv1(1'b0, 1'b0, 1'b0, '0, '0);
        repeat (4) tick;

        // Reset one cycle after a read accept; pointer had moved to m1.
        drv0(1'b1, 1'b0, 1'b0, 10'h003, '0);
        drv1(1'b1, 1'b1, 1'b0, 10'h070, 32'h7777_7777);
        @(negedge HCLK);
        chk1("rs_gnt0", u_m0.gnt, 1'b1);
        tick;
        drv0(1'b0, 1'b0, 1'b0, '0, '0);
        RST = 1'b1;
        @(negedge HCLK);
        chk1("rs_gnt1_in_reset", u_m1.gnt, 1'b0);
        chk1("rs_read_issued", mem_en, 1'b1);
        tick;
        RST = 1'b0;
        drv0(1'b1, 1'b1, 1'b0, 10'h050, 32'h5555_5555);
        @(negedge HCLK);
        chk1("rs_mem_en", mem_en, 1'b0);
        chkw("rs_mem_addr", 32'(mem_addr), 32'h0);
        chkw("rs_rvalid", {30'b0, u_m1.rvalid, u_m0.rvalid}, 32'h0);
        chk1("rs_gnt0_wins", u_m0.gnt, 1'b1);
        chk1("rs_gnt1_loses", u_m1.gnt, 1'b0);
        tick;
        drv0(1'b0, 1'b0, 1'b0, '0, '0);
        drv1(1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge HCLK);
        chkw("rs_m0_addr", 32'(mem_addr), 32'h050);
        repeat (4) tick;

        @(negedge HCLK);
        chkw("sb_drain", 32'(sb_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
